// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, receiver/transmitter FSM states and
// the bit-period helper used by both ends of the link.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Integer divide truncates; the residual baud error is absorbed by mid-bit sampling.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous input pins; the reset value
// matches the pin's idle level so no false edge appears when reset releases.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling, stop check,
// and a single-entry valid/ready holding register with overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun,
    output uart_state_e state_dbg
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                 rx_s;
    logic                 rx_s_prev_q;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 commit_q, commit_d;
    logic                 frame_err_q, frame_err_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 overrun_q, overrun_d;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s_prev_q <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_s_prev_q <= rx_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame FSM. Only a high-to-low transition starts a frame, so a line stuck
    // low after a framing error stays quiet until it recovers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s && rx_s_prev_q) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    commit_d    = rx_s;
                    frame_err_d = !rx_s;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: a commit wins over a same-cycle drain, and a commit
    // into an undrained register drops the new byte rather than the old one.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (commit_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural 8N1 line driver, a frame-level
// delivery model (expected byte queue, error/overrun tallies) and directed plus random frames.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int TB_CLK_FREQ = 2_000_000;
    localparam int TB_BAUD     = 100_000;
    localparam int CPB         = TB_CLK_FREQ / TB_BAUD;
    // Start-detect to valid: 2 sync + 1 edge + half bit + 9 bits - 1 + 1 commit.
    localparam int LAT         = 2 + 1 + CPB / 2 + 9 * CPB - 1 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    uart_state_e state_dbg;

    uart_rx #(
        .CLK_FREQ(TB_CLK_FREQ),
        .BAUD(TB_BAUD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         rise_q[$];
    bit         model_full = 1'b0;
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    bit         prev_valid = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         last_start = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor sits on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_valid && !prev_valid) rise_q.push_back(cyc);
            prev_valid = rx_valid;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
                model_full = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Sends one frame; the line is left at the stop level. The delivery model
    // decides the byte's fate when the stop bit goes out, ahead of the commit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        last_start = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        if (stop_bit) begin
            if (rx_ready || !model_full) begin
                exp_q.push_back(b);
                model_full = 1'b1;
            end else begin
                exp_ovr++;
            end
        end else begin
            exp_ferr++;
        end
        tick(CPB);
    endtask

    task automatic check_tallies(input string tag);
        check_eq({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
        check_eq({tag, "_ovr"}, 32'(ovr_cnt), 32'(exp_ovr));
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat[3];
        int         t0;
        logic [7:0] rb;
        logic       rs;

        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h55;

        tick(3);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        tick(3);

        // 1: single byte, latency from first sampled low edge
        rise_q.delete();
        send_frame(8'hA5, 1'b1);
        t0 = last_start;
        tick(CPB);
        check_eq("t1_count", 32'(rise_q.size()), 32'd1);
        check_eq("t1_latency", 32'(rise_q[0]), 32'(t0 + 1 + LAT));
        check_tallies("t1");

        // 2: back-to-back frames, one frame period apart
        rise_q.delete();
        t0 = cyc;
        for (int i = 0; i < 3; i++) send_frame(pat[i], 1'b1);
        tick(CPB);
        check_eq("t2_count", 32'(rise_q.size()), 32'd3);
        check_eq("t2_latency", 32'(rise_q[0]), 32'(t0 + 1 + LAT));
        for (int i = 0; i < 2; i++)
            check_eq("t2_spacing", 32'(rise_q[i+1] - rise_q[i]), 32'(10 * CPB));
        check_tallies("t2");

        // 3: short low glitch is rejected at the half-bit sample
        rise_q.delete();
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        check_eq("t3_in_start", 32'(state_dbg), 32'(START));
        tick(3 + CPB / 2 + 2 - CPB / 4);
        check_eq("t3_back_idle", 32'(state_dbg), 32'(IDLE));
        tick(CPB);
        check_eq("t3_no_valid", 32'(rise_q.size()), 32'd0);
        check_tallies("t3");

        // 4: bad stop bit, then the line stays low
        rise_q.delete();
        send_frame(8'h3C, 1'b0);
        tick(3 * CPB);
        check_eq("t4_idle_low", 32'(state_dbg), 32'(IDLE));
        check_eq("t4_no_valid", 32'(rise_q.size()), 32'd0);
        check_tallies("t4");
        rx = 1'b1;
        tick(CPB);

        // 5: consumer stalled, second byte overruns
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(CPB);
        check_eq("t5_valid", 32'(rx_valid), 32'd1);
        check_eq("t5_held", 32'(rx_data), 32'h11);
        check_eq("t5_ovr", 32'(ovr_cnt), 32'(exp_ovr));
        rx_ready = 1'b1;
        tick(1);
        check_eq("t5_drop", 32'(rx_valid), 32'd0);
        tick(CPB);
        check_tallies("t5");

        // 6: reset mid-frame with a full holding register
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        tick(CPB);
        rb = 8'h7E;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            tick(CPB);
        end
        rx = rb[4];
        tick(CPB / 2);
        check_eq("t6_in_data", 32'(state_dbg), 32'(DATA));
        rst = 1'b1;
        tick(2);
        check_eq("t6_rst_valid", 32'(rx_valid), 32'd0);
        check_eq("t6_rst_data", 32'(rx_data), 32'd0);
        check_eq("t6_rst_ferr", 32'(frame_err), 32'd0);
        check_eq("t6_rst_state", 32'(state_dbg), 32'(IDLE));
        exp_q.delete();
        model_full = 1'b0;
        rx = 1'b1;
        rst = 1'b0;
        tick(2 * CPB);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1);
        tick(CPB);
        check_tallies("t6");

        // random frames: random data, occasional bad stop, random stall and gap
        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 5) != 0);
            rx_ready = 1'($urandom_range(0, 1));
            send_frame(rb, rs);
            rx = 1'b1;
            tick($urandom_range(rs ? 0 : 1, CPB));
        end
        rx_ready = 1'b1;
        tick(2 * CPB);
        check_tallies("rand");

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
